pc_seq: RTL and testbench

Parametrised program-counter sequencer for the multi-phase core. It owns the one-hot phase ring and the PC register, and selects the next PC from the incrementer, an ALU-computed target or an optional return-address stack (RAS). The PC updates once per instruction, in the write-back phase. It sits between the ALU result bus and the instruction-memory address port.

---
 rtl/pc_seq.sv | 90 +++++++++
 tb/tb_pc_seq.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/pc_seq.sv
// pc_seq: one-hot phase ring, PC register and next-PC select; define PC_SEQ_RAS_EN to add the return-address stack.
module pc_seq #(
  parameter int ADDR_W    = 12,
  parameter int INSTR_W   = 16,
  parameter int NPHASE    = 5,
  parameter int WB_PHASE  = 3,
  parameter int RAS_DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               stall,
  input  logic [INSTR_W-1:0] instr,
  input  logic [INSTR_W-1:0] result,
  output logic [NPHASE-1:0]  phase,
  output logic [ADDR_W-1:0]  pc,
  output logic [ADDR_W-1:0]  next_pc,
  output logic               pc_enable,
  output logic               ras_empty,
  output logic               ras_full,
  output logic               ras_err
);
  logic [NPHASE-1:0] phase_q, phase_d;
  logic [ADDR_W-1:0] pc_q, pc_d, pc_inc, target;
  logic [4:0]        op;
  logic              is_jmp, is_call;
  assign op        = instr[INSTR_W-1 -: 5];
  assign is_jmp    = (op == 5'b10111) || (op == 5'b10100);
  assign is_call   = op == 5'b10101;
  assign pc_inc    = pc_q + ADDR_W'(1);
  assign target    = result[ADDR_W-1:0];
  assign pc_enable = phase_q[WB_PHASE] & ~stall;
  assign phase     = phase_q;
  assign pc        = pc_q;
  always_comb begin
    phase_d = stall ? phase_q : {phase_q[NPHASE-2:0], phase_q[NPHASE-1]};
    pc_d    = pc_enable ? next_pc : pc_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q <= NPHASE'(1);
      pc_q    <= '0;
    end else begin
      phase_q <= phase_d;
      pc_q    <= pc_d;
    end
  end
`ifdef PC_SEQ_RAS_EN
  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = $clog2(RAS_DEPTH + 1);
  logic [ADDR_W-1:0] ras_mem [RAS_DEPTH];
  logic [PW-1:0]     top_q, top_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              err_q, err_d, is_ret, empty, full, push, pop, under;
  assign is_ret    = op == 5'b10110;
  assign empty     = cnt_q == '0;
  assign full      = cnt_q == CW'(RAS_DEPTH);
  assign push      = pc_enable & is_call;
  assign pop       = pc_enable & is_ret & ~empty;
  assign under     = pc_enable & is_ret & empty;
  assign ras_empty = empty;
  assign ras_full  = full;
  assign ras_err   = err_q;
  // top_q always addresses the newest entry; a full push wraps onto the oldest
  always_comb begin
    next_pc = (is_jmp | is_call) ? target : (is_ret & ~empty) ? ras_mem[top_q] : pc_inc;
    top_d   = push ? top_q + PW'(1) : pop ? top_q - PW'(1) : top_q;
    cnt_d   = (push & ~full) ? cnt_q + CW'(1) : pop ? cnt_q - CW'(1) : cnt_q;
    err_d   = err_q | (push & full) | under;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      top_q <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      top_q <= top_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push) ras_mem[top_d] <= pc_inc;
  end
`else
  assign next_pc   = (is_jmp | is_call) ? target : pc_inc;
  assign ras_empty = 1'b1;
  assign ras_full  = 1'b0;
  assign ras_err   = 1'b0;
`endif
endmodule

// File: tb/tb_pc_seq.sv
// tb_pc_seq: directed and random checks of pc_seq against a queue-based model of the PC/RAS rules.
module tb_pc_seq;
  localparam int AW = 12, IW = 16, NP = 5, WB = 3, DEPTH = 4;
  localparam logic [4:0] JMP = 5'b10111, BR = 5'b10100, CALL = 5'b10101, RET = 5'b10110;
`ifdef PC_SEQ_RAS_EN
  localparam bit RAS_EN = 1'b1;
`else
  localparam bit RAS_EN = 1'b0;
`endif
  logic clk = 1'b0, rst_n = 1'b0, stall = 1'b0;
  logic [IW-1:0] instr = '0, result = '0;
  logic [NP-1:0] phase;
  logic [AW-1:0] pc, next_pc;
  logic pc_enable, ras_empty, ras_full, ras_err;
  int checks = 0, errors = 0;
  int ph;
  logic [AW-1:0] mpc;
  logic [AW-1:0] mras[$];
  bit merr;

  pc_seq dut (.clk(clk), .rst_n(rst_n), .stall(stall), .instr(instr), .result(result),
              .phase(phase), .pc(pc), .next_pc(next_pc), .pc_enable(pc_enable),
              .ras_empty(ras_empty), .ras_full(ras_full), .ras_err(ras_err));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    ph = 0;
    mpc = '0;
    mras.delete();
    merr = 0;
  endtask

  // starts and ends just after a falling edge
  task automatic cycle(input bit st, input logic [4:0] op, input logic [IW-1:0] res);
    logic [AW-1:0] nxt;
    bit en;
    stall = st;
    instr = {op, 11'($urandom)};
    result = res;
    #1;
    if (op == JMP || op == BR || (op == CALL)) nxt = res[AW-1:0];
    else if (op == RET && RAS_EN && mras.size() > 0) nxt = mras[$];
    else nxt = mpc + 1'b1;
    en = (ph == WB) && !st;
    chk("phase", 32'(phase), 32'(1 << ph));
    chk("pc", 32'(pc), 32'(mpc));
    chk("next_pc", 32'(next_pc), 32'(nxt));
    chk("pc_enable", 32'(pc_enable), 32'(en));
    chk("ras_empty", 32'(ras_empty), 32'(mras.size() == 0));
    chk("ras_full", 32'(ras_full), 32'(RAS_EN && mras.size() == DEPTH));
    chk("ras_err", 32'(ras_err), 32'(merr));
    @(posedge clk);
    if (en) begin
      if (RAS_EN && op == CALL) begin
        mras.push_back(mpc + 1'b1);
        if (mras.size() > DEPTH) begin
          void'(mras.pop_front());
          merr = 1;
        end
      end
      if (RAS_EN && op == RET) begin
        if (mras.size() > 0) void'(mras.pop_back());
        else merr = 1;
      end
      mpc = nxt;
    end
    if (!st) ph = (ph + 1) % NP;
    @(negedge clk);
  endtask

  task automatic run_instr(input logic [4:0] op, input logic [IW-1:0] res);
    for (int i = 0; i < NP; i++) cycle(1'b0, op, res);
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_pc", 32'(pc), 32'h0);
    chk("rst_phase", 32'(phase), 32'h1);
    chk("rst_empty", 32'(ras_empty), 32'h1);
    chk("rst_full", 32'(ras_full), 32'h0);
    chk("rst_err", 32'(ras_err), 32'h0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [4:0] op;
    model_reset();
    repeat (2) @(negedge clk);
    chk("por_pc", 32'(pc), 32'h0);
    chk("por_phase", 32'(phase), 32'h1);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) cycle(1'b0, 5'd0, '0);
    chk("seq_pc", 32'(pc), 32'h2);
    run_instr(JMP, 16'h0FFF);
    chk("jmp_fff", 32'(pc), 32'hFFF);
    run_instr(5'd3, '0);
    chk("wrap", 32'(pc), 32'h000);
    run_instr(JMP, 16'h1234);
    chk("jmp_trunc", 32'(pc), 32'h234);
    for (int i = 0; i < WB; i++) cycle(1'b0, 5'd1, '0);
    for (int i = 0; i < 3; i++) cycle(1'b1, 5'd1, '0);
    chk("stall_hold", 32'(pc), 32'h234);
    cycle(1'b0, 5'd1, '0);
    chk("stall_upd", 32'(pc), 32'h235);
    cycle(1'b0, 5'd1, '0);
    run_instr(JMP, 16'h0010);
    run_instr(CALL, 16'h0100);
    chk("call1", 32'(pc), 32'h100);
    run_instr(CALL, 16'h0200);
    run_instr(RET, '0);
    chk("ret1", 32'(pc), RAS_EN ? 32'h101 : 32'h201);
    run_instr(RET, '0);
    chk("ret2", 32'(pc), RAS_EN ? 32'h011 : 32'h202);
    chk("ret_empty", 32'(ras_empty), 32'h1);
    chk("ret_err", 32'(ras_err), 32'h0);
    for (int i = 0; i < 5; i++) run_instr(CALL, 16'(16'h300 + i * 16'h10));
    chk("ovf_full", 32'(ras_full), 32'(RAS_EN));
    chk("ovf_err", 32'(ras_err), 32'(RAS_EN));
    for (int i = 0; i < 5; i++) run_instr(RET, '0);
    chk("unf_err", 32'(ras_err), 32'(RAS_EN));
    run_instr(CALL, 16'h0400);
    run_instr(CALL, 16'h0500);
    cycle(1'b0, 5'd2, '0);
    cycle(1'b0, 5'd2, '0);
    do_reset();
    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 5))
        0: op = JMP;
        1: op = BR;
        2: op = CALL;
        3, 4: op = RET;
        default: op = 5'($urandom_range(0, 19));
      endcase
      cycle($urandom_range(0, 7) == 0, op, 16'($urandom));
      if ($urandom_range(0, 150) == 0) do_reset();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
